// File: rtl/mem_stage.sv
// mem_stage: MIPS MEM stage with latency-configurable data memory, branch/jump redirect and MEM/WB register
module mem_stage #(
  parameter int DEPTH       = 256,
  parameter int MEM_LATENCY = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        wb_reg_write_in,
  input  logic        wb_mem_to_reg_in,
  input  logic        m_branch_in,
  input  logic        m_mem_read_in,
  input  logic        m_mem_write_in,
  input  logic [31:0] adder_in,
  input  logic [31:0] alu_result_in,
  input  logic [31:0] read_data2_in,
  input  logic        zero_flag_in,
  input  logic [4:0]  write_reg_in,
  input  logic        jump_in,
  input  logic [27:0] new_shift_in,
  input  logic [3:0]  pc_upper_in,
  output logic        pc_src_out,
  output logic        jump_taken_out,
  output logic [31:0] branch_target_out,
  output logic [31:0] jump_target_out,
  output logic        stall_out,
  output logic        misaligned_out,
  output logic        wb_reg_write_out,
  output logic        wb_mem_to_reg_out,
  output logic [31:0] read_data_out,
  output logic [31:0] alu_result_out,
  output logic [4:0]  write_reg_out
);
  localparam int AW = $clog2(DEPTH);
  typedef enum logic {IDLE, BUSY} state_t;
  state_t      state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [31:0] mem [DEPTH];
  logic [AW-1:0] idx;
  logic        mem_op, req, mis, last, stall, done, we;
  logic        wb_rw_q, wb_rw_d, m2r_q, m2r_d, mis_q, mis_d;
  logic [31:0] rdata_q, rdata_d, alu_q, alu_d;
  logic [4:0]  wreg_q, wreg_d;
  always_comb begin
    idx     = alu_result_in[AW+1:2];
    mem_op  = m_mem_read_in | m_mem_write_in;
    req     = mem_op & (alu_result_in[1:0] == 2'b00);
    mis     = mem_op & (|alu_result_in[1:0]);
    last    = (state_q == BUSY) && (cnt_q == 3'(MEM_LATENCY - 1));
    stall   = rst_n & ((state_q == BUSY) ? !last : (req & (MEM_LATENCY > 1)));
    done    = req & !stall;
    we      = done & m_mem_write_in & rst_n;
    state_d = stall ? BUSY : IDLE;
    cnt_d   = stall ? cnt_q + 3'd1 : 3'd0;
    wb_rw_d = stall ? 1'b0 : wb_reg_write_in;
    m2r_d   = stall ? 1'b0 : wb_mem_to_reg_in;
    alu_d   = stall ? 32'd0 : alu_result_in;
    wreg_d  = stall ? 5'd0 : write_reg_in;
    mis_d   = !stall & mis;
    rdata_d = (done & m_mem_read_in & !m_mem_write_in) ? mem[idx] : 32'd0;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= 3'd0;
      wb_rw_q <= 1'b0;
      m2r_q   <= 1'b0;
      mis_q   <= 1'b0;
      rdata_q <= 32'd0;
      alu_q   <= 32'd0;
      wreg_q  <= 5'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      wb_rw_q <= wb_rw_d;
      m2r_q   <= m2r_d;
      mis_q   <= mis_d;
      rdata_q <= rdata_d;
      alu_q   <= alu_d;
      wreg_q  <= wreg_d;
    end
  end
  always_ff @(posedge clk) begin
    if (we) mem[idx] <= read_data2_in;
  end
  assign stall_out         = stall;
  assign jump_taken_out    = jump_in & !stall;
  assign pc_src_out        = m_branch_in & zero_flag_in & !jump_in & !stall;
  assign branch_target_out = adder_in;
  assign jump_target_out   = {pc_upper_in, new_shift_in};
  assign misaligned_out    = mis_q;
  assign wb_reg_write_out  = wb_rw_q;
  assign wb_mem_to_reg_out = m2r_q;
  assign read_data_out     = rdata_q;
  assign alu_result_out    = alu_q;
  assign write_reg_out     = wreg_q;
endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: randomized scoreboard bench for mem_stage against a word-array memory model
module tb_mem_stage;
  localparam int DEPTH = 256;
  localparam int LAT   = 2;
  logic clk = 0, rst_n = 0;
  logic wb_reg_write_in, wb_mem_to_reg_in, m_branch_in, m_mem_read_in, m_mem_write_in;
  logic [31:0] adder_in, alu_result_in, read_data2_in;
  logic zero_flag_in, jump_in;
  logic [4:0] write_reg_in;
  logic [27:0] new_shift_in;
  logic [3:0] pc_upper_in;
  logic pc_src_out, jump_taken_out, stall_out, misaligned_out, wb_reg_write_out, wb_mem_to_reg_out;
  logic [31:0] branch_target_out, jump_target_out, read_data_out, alu_result_out;
  logic [4:0] write_reg_out;
  typedef struct packed {
    logic [31:0] rd;
    logic [31:0] alu;
    logic [4:0]  wreg;
    logic        m2r;
    logic        mis;
  } exp_t;
  exp_t exp_q[$];
  logic [31:0] mdl [DEPTH];
  int checks = 0, errors = 0;
  mem_stage #(.DEPTH(DEPTH), .MEM_LATENCY(LAT)) dut (
    .clk(clk), .rst_n(rst_n),
    .wb_reg_write_in(wb_reg_write_in), .wb_mem_to_reg_in(wb_mem_to_reg_in),
    .m_branch_in(m_branch_in), .m_mem_read_in(m_mem_read_in), .m_mem_write_in(m_mem_write_in),
    .adder_in(adder_in), .alu_result_in(alu_result_in), .read_data2_in(read_data2_in),
    .zero_flag_in(zero_flag_in), .write_reg_in(write_reg_in), .jump_in(jump_in),
    .new_shift_in(new_shift_in), .pc_upper_in(pc_upper_in),
    .pc_src_out(pc_src_out), .jump_taken_out(jump_taken_out),
    .branch_target_out(branch_target_out), .jump_target_out(jump_target_out),
    .stall_out(stall_out), .misaligned_out(misaligned_out),
    .wb_reg_write_out(wb_reg_write_out), .wb_mem_to_reg_out(wb_mem_to_reg_out),
    .read_data_out(read_data_out), .alu_result_out(alu_result_out), .write_reg_out(write_reg_out)
  );
  always #5 clk = ~clk;
  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %h expected %h", n, a, e);
    end
  endtask
  task automatic idle_inputs();
    {wb_reg_write_in, wb_mem_to_reg_in, m_branch_in, m_mem_read_in, m_mem_write_in} = '0;
    {adder_in, alu_result_in, read_data2_in} = '0;
    {zero_flag_in, jump_in, write_reg_in, new_shift_in, pc_upper_in} = '0;
  endtask
  task automatic issue(input logic rd, input logic wr, input logic [31:0] addr, input logic [31:0] data,
                       input logic [4:0] wreg, input logic br, input logic z, input logic j,
                       input logic [31:0] tgt, input logic [27:0] sh, input logic [3:0] up);
    logic acc;
    int idx, nst;
    exp_t e;
    wb_reg_write_in = 1; wb_mem_to_reg_in = rd; m_mem_read_in = rd; m_mem_write_in = wr;
    alu_result_in = addr; read_data2_in = data; write_reg_in = wreg;
    m_branch_in = br; zero_flag_in = z; jump_in = j; adder_in = tgt; new_shift_in = sh; pc_upper_in = up;
    acc = (rd | wr) && addr[1:0] == 2'b00;
    idx = int'((addr / 4) % DEPTH);
    e.rd = (acc && rd && !wr) ? mdl[idx] : 32'd0;
    e.alu = addr; e.wreg = wreg; e.m2r = rd; e.mis = (rd | wr) && !acc;
    if (acc && wr) mdl[idx] = data;
    exp_q.push_back(e);
    nst = acc ? LAT - 1 : 0;
    for (int c = 0; c <= nst; c++) begin
      @(negedge clk);
      chk("stall", stall_out, c < nst);
      chk("jump_taken", jump_taken_out, (c < nst) ? 1'b0 : j);
      chk("pc_src", pc_src_out, (c < nst) ? 1'b0 : (br & z & !j));
      chk("branch_target", branch_target_out, tgt);
      chk("jump_target", jump_target_out, {up, sh});
      @(posedge clk); #1;
    end
  endtask
  always @(negedge clk) begin
    if (rst_n) begin
      if (wb_reg_write_out) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_wb", 32'd1, 32'd0);
        end else begin
          exp_exp_pop();
        end
      end else begin
        chk("bubble", {wb_mem_to_reg_out, misaligned_out, write_reg_out} | read_data_out | alu_result_out, 32'd0);
      end
    end
  end
  task automatic exp_exp_pop();
    exp_t e;
    e = exp_q.pop_front();
    chk("read_data", read_data_out, e.rd);
    chk("alu_result", alu_result_out, e.alu);
    chk("write_reg", {27'd0, write_reg_out}, {27'd0, e.wreg});
    chk("mem_to_reg", wb_mem_to_reg_out, e.m2r);
    chk("misaligned", misaligned_out, e.mis);
  endtask
  initial begin
    idle_inputs();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_stall", stall_out, 0);
    chk("rst_wb", {wb_reg_write_out, wb_mem_to_reg_out, misaligned_out, write_reg_out} | read_data_out | alu_result_out, 0);
    rst_n = 1;
    for (int i = 0; i < DEPTH; i++) issue(0, 1, i * 4, $urandom, 0, 0, 0, 0, 0, 0, 0);
    issue(0, 1, 32'h10, 32'hDEADBEEF, 0, 0, 0, 0, 0, 0, 0);
    issue(1, 0, 32'h10, 0, 8, 0, 0, 0, 0, 0, 0);
    issue(1, 0, 32'h13, 0, 3, 0, 0, 0, 0, 0, 0);
    issue(0, 1, 32'h11, 32'h12345678, 4, 0, 0, 0, 0, 0, 0);
    issue(1, 0, 32'h10, 0, 5, 0, 0, 0, 0, 0, 0);
    issue(0, 1, 32'h400, 32'h55, 0, 0, 0, 0, 0, 0, 0);
    issue(1, 0, 32'h0, 0, 9, 0, 0, 0, 0, 0, 0);
    issue(1, 1, 32'h24, 32'hA5A5A5A5, 6, 0, 0, 0, 0, 0, 0);
    issue(1, 0, 32'h24, 0, 7, 0, 0, 0, 0, 0, 0);
    issue(0, 0, 32'h7, 0, 1, 1, 1, 0, 32'h40, 0, 0);
    issue(0, 0, 32'h7, 0, 1, 1, 1, 1, 32'h40, 28'h0000100, 4'h0);
    issue(1, 0, 32'h8, 0, 2, 1, 1, 0, 32'h80, 28'h0000200, 4'hA);
    issue(0, 1, 32'hC, 32'h1, 2, 0, 1, 1, 32'h80, 28'h0000200, 4'hA);
    // abort a store mid-access with reset; the old word must survive
    @(negedge clk);
    wb_reg_write_in = 1; m_mem_write_in = 1; alu_result_in = 32'h20; read_data2_in = 32'hCAFEF00D;
    @(posedge clk); #1;
    rst_n = 0; #1;
    chk("abort_stall", stall_out, 0);
    chk("abort_wb", {wb_reg_write_out, wb_mem_to_reg_out, misaligned_out, write_reg_out} | read_data_out | alu_result_out, 0);
    @(posedge clk); #1;
    idle_inputs();
    rst_n = 1;
    issue(1, 0, 32'h20, 0, 11, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 400; i++) begin
      logic [1:0] op;
      logic [31:0] a;
      op = 2'($urandom_range(0, 3));
      a = $urandom;
      if ($urandom_range(0, 3) != 0) a[1:0] = 2'b00;
      issue(op[0], op[1], a, $urandom, 5'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
            $urandom, 28'($urandom), 4'($urandom));
    end
    idle_inputs();
    repeat (3) @(posedge clk);
    #1;
    chk("queue_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- MEM stage of the 5-stage MIPS pipeline, directly downstream of the EX/MEM register; consumes its outputs.
- Owns the word-addressed data memory, with a configurable-latency access FSM that stalls the pipeline during multi-cycle accesses.
- Resolves branch/jump redirection for the fetch stage.
- Contains the MEM/WB pipeline register, which feeds write-back.

Parameters:
- DEPTH, 256, data memory size in 32-bit words (power of 2, 16..4096).
- MEM_LATENCY, 2, cycles per data access (1..7); 1 means single-cycle, no stall.

Ports:
- clk  in  1  pipeline clock; all state on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- wb_reg_write_in  in  1  RegWrite from EX/MEM.
- wb_mem_to_reg_in  in  1  MemtoReg from EX/MEM.
- m_branch_in  in  1  Branch control.
- m_mem_read_in  in  1  load request.
- m_mem_write_in  in  1  store request.
- adder_in  in  32  branch target.
- alu_result_in  in  32  ALU result / byte address.
- read_data2_in  in  32  store data.
- zero_flag_in  in  1  ALU zero.
- write_reg_in  in  5  destination register.
- jump_in  in  1  j instruction.
- new_shift_in  in  28  jump index << 2.
- pc_upper_in  in  4  PC+4[31:28] for jump target.
- pc_src_out  out  1  take branch target.
- jump_taken_out  out  1  take jump target.
- branch_target_out  out  32  equals adder_in.
- jump_target_out  out  32  {pc_upper_in, new_shift_in}.
- stall_out  out  1  freeze PC, IF/ID, ID/EX, EX/MEM.
- misaligned_out  out  1  registered: last access had alu_result_in[1:0]!=0.
- wb_reg_write_out  out  1  MEM/WB RegWrite.
- wb_mem_to_reg_out  out  1  MEM/WB MemtoReg.
- read_data_out  out  32  MEM/WB load data.
- alu_result_out  out  32  MEM/WB ALU result.
- write_reg_out  out  5  MEM/WB destination.

Behaviour:
- Reset (async, rst_n=0): FSM to IDLE, latency counter=0.
- Reset values: all MEM/WB outputs 0, misaligned_out=0, stall_out=0.
- Memory array is not reset; contents survive rst_n. An access in flight at reset is aborted and no write occurs.
- Addressing: word index = alu_result_in[log2(DEPTH)+1:2]; upper bits are ignored, so addresses wrap modulo DEPTH words.
- Access request: (m_mem_read_in | m_mem_write_in) & (alu_result_in[1:0]==0).
- Misaligned request: no memory access, no stall. MEM/WB loads normally with read_data_out=0 and misaligned_out=1 for that instruction.
- Both read and write set: treated as a write; read_data_out=0.
- FSM states: IDLE, BUSY.
- IDLE, request present and MEM_LATENCY=1: write on this edge; the MEM/WB register captures read data from the array (read-before-write on the same address: returns old data).
- IDLE, request present and MEM_LATENCY>1: stall_out=1 combinationally this cycle; counter <= 1; go to BUSY; MEM/WB loads a bubble (wb_reg_write_out=0, wb_mem_to_reg_out=0, other fields 0).
- BUSY, counter < MEM_LATENCY-1: stall_out=1; counter increments; MEM/WB bubble.
- BUSY, counter == MEM_LATENCY-1: stall_out=0 (completion cycle); write is performed or read data is captured into MEM/WB with the full instruction fields; go to IDLE.
- Net effect: an access occupies MEM_LATENCY cycles with stall_out high for MEM_LATENCY-1 of them.
- Upstream must hold all *_in stable while stall_out=1; this block samples only in the completion cycle.
- Non-memory instruction: MEM/WB loads on every edge (1-cycle latency); read_data_out=0.
- Redirect, combinational and gated by !stall_out:
  - jump_taken_out = jump_in.
  - pc_src_out = m_branch_in & zero_flag_in & !jump_in (jump has priority when both are set).
- branch_target_out and jump_target_out are always driven, ungated.
- Back-to-back accesses: IDLE is re-entered in the completion cycle and a new request is evaluated on the following cycle; no extra bubble is added beyond the latency.

Test Plan:
- Reset: rst_n=0 mid-BUSY -> stall_out=0 and all MEM/WB outputs 0 immediately; FSM IDLE; a subsequent read of the target address shows the old data (aborted write).
- Store/load, MEM_LATENCY=2: sw 0xDEADBEEF at addr 0x10, then lw addr 0x10 with write_reg_in=8 -> stall_out high 1 cycle per access; after the lw completion edge, read_data_out=0xDEADBEEF, write_reg_out=8, wb_mem_to_reg_out=1; one bubble per access.
- Latency sweep, MEM_LATENCY=1 and 4: lw -> stall pulse of 0 and 3 cycles respectively; data correct.
- Misaligned: lw alu_result_in=0x13 -> no stall, misaligned_out=1, read_data_out=0, memory unchanged.
- Wrap: DEPTH=256, sw 0x55 at 0x400 then lw 0x0 -> read_data_out=0x55.
- Redirect:
  - m_branch_in=1, zero=1, adder_in=0x40 -> pc_src_out=1, branch_target_out=0x40.
  - Add jump_in=1, pc_upper_in=0x0, new_shift_in=0x0000100 -> jump_taken_out=1, pc_src_out=0, jump_target_out=0x00000100.
  - Any redirect during stall_out=1 -> both 0.
